execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: none; all widths fixed (32-bit data, 4-bit register index, 4-bit opcode).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 InValid  input  1  operand bundle valid.
REQ-005 InReady  output  1  stage can accept; SHALL be 1 exactly when FSM is IDLE.
REQ-006 Opcode  input  4  operation select.
REQ-007 Destination  input  4  destination register index, carried to WbDest.
REQ-008 Source1  input  32  operand A (register-file read port 1).
REQ-009 Source2  input  32  operand B (register-file read port 2).
REQ-010 WbEn  output  1  one-cycle register-file write strobe.
REQ-011 WbDest  output  4  register-file write index.
REQ-012 WbData  output  32  register-file write data.
REQ-013 Zero  output  1  WbData==0 at the last writeback.
REQ-014 Carry  output  1  carry/borrow from the last writeback.
REQ-015 Busy  output  1  high while in MUL state.

Function
REQ-016 Transfer SHALL occur on a rising edge with InValid=1 and InReady=1; inputs SHALL be ignored otherwise.
REQ-017 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL, 11 PASS (WbData=Source2), 12-15 reserved.
REQ-018 Shifts SHALL use Source2[4:0] as amount; SLT/SLTU SHALL produce 32'd1 or 32'd0.
REQ-019 ADD/SUB SHALL wrap modulo 2^32; Carry = bit-32 carry-out for ADD, borrow (Source1<Source2 unsigned) for SUB, 0 for all other ops.
REQ-020 FSM states: IDLE, MUL. IDLE->MUL on transfer with Opcode 10; MUL->IDLE after the 32nd iteration; all other transfers stay in IDLE.
REQ-021 Single-cycle op accepted at edge E: WbEn=1, WbDest, WbData, Zero, Carry SHALL update at E and WbEn SHALL fall at E+1 unless another op completes at E+1.
REQ-022 MUL SHALL be an iterative shift-add multiplier, one multiplicand bit per cycle, producing the low 32 bits of the unsigned product.
REQ-023 MUL accepted at edge E: operands and Destination latched at E; iterations at edges E+1..E+32; WbEn=1 with result from E+32 for one cycle; InReady=0 and Busy=1 from E to E+32.
REQ-024 A transfer presented in the cycle InReady returns to 1 SHALL be accepted at the next edge; back-to-back single-cycle ops SHALL sustain one writeback per cycle, in order.
REQ-025 Reserved opcodes SHALL be accepted and SHALL produce WbEn=0 for that cycle; WbDest/WbData/Zero/Carry SHALL hold.
REQ-026 WbDest, WbData, Zero, Carry SHALL hold their values between writebacks.
REQ-027 Destination 0 SHALL be treated as an ordinary register (no suppression).

Reset
REQ-028 While rst=1: state IDLE, iteration counter 0, WbEn=0, WbDest=0, WbData=0, Zero=0, Carry=0, Busy=0, immediately (asynchronous).
REQ-029 Reset during MUL SHALL abort the multiply; no WbEn SHALL be produced for it after rst falls.
REQ-030 InReady SHALL be 1 during reset (IDLE) but no transfer SHALL occur on any edge where rst=1.

Verification
REQ-031 ADD 0xFFFFFFFF+0x00000001, Destination 3 -> next cycle WbEn=1, WbDest=3, WbData=0, Zero=1, Carry=1.
REQ-032 SUB 5-7 -> WbData=0xFFFFFFFE, Carry=1, Zero=0; SRA 0x80000000 by 4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-033 MUL 0x00010003*0x00000005, Destination 7 -> InReady low 32 cycles, then WbEn=1, WbDest=7, WbData=0x0005000F; an ADD held with InValid=1 throughout is accepted on the edge after InReady rises.
REQ-034 Eight back-to-back ops (ADD, AND, OR, XOR, SLL, SRL, PASS, reserved 13) on consecutive cycles -> seven consecutive WbEn pulses with correct data in order, then WbEn=0 for opcode 13 with outputs held.
REQ-035 rst asserted mid-cycle at MUL iteration 10 -> all outputs 0 without waiting for clk; after release no WbEn appears; subsequent ADD 2+2 -> WbData=4.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration shift-add multiplier.
// ALU results register on the accepting edge; MUL writes back 32 edges after acceptance.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic [3:0]  Opcode,
  input  logic [3:0]  Destination,
  input  logic [31:0] Source1,
  input  logic [31:0] Source2,
  output logic        WbEn,
  output logic [3:0]  WbDest,
  output logic [31:0] WbData,
  output logic        Zero,
  output logic        Carry,
  output logic        Busy
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [3:0]  mdest_q;
  logic        wb_en_q;
  logic [3:0]  wb_dest_q;
  logic [31:0] wb_data_q;
  logic        zero_q;
  logic        carry_q;

  logic [32:0] sum_d;
  logic [31:0] alu_res_d;
  logic        alu_carry_d;
  logic        alu_wb_d;
  logic [31:0] acc_d;
  logic [4:0]  shamt;

  assign shamt = Source2[4:0];
  assign sum_d = {1'b0, Source1} + {1'b0, Source2};
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_comb begin
    alu_res_d   = 32'd0;
    alu_carry_d = 1'b0;
    alu_wb_d    = 1'b1;
    case (Opcode)
      OP_ADD:  begin alu_res_d = sum_d[31:0]; alu_carry_d = sum_d[32]; end
      OP_SUB:  begin alu_res_d = Source1 - Source2; alu_carry_d = (Source1 < Source2); end
      OP_AND:  alu_res_d = Source1 & Source2;
      OP_OR:   alu_res_d = Source1 | Source2;
      OP_XOR:  alu_res_d = Source1 ^ Source2;
      OP_SLL:  alu_res_d = Source1 << shamt;
      OP_SRL:  alu_res_d = Source1 >> shamt;
      OP_SRA:  alu_res_d = $unsigned($signed(Source1) >>> shamt);
      OP_SLT:  alu_res_d = {31'd0, ($signed(Source1) < $signed(Source2))};
      OP_SLTU: alu_res_d = {31'd0, (Source1 < Source2)};
      OP_PASS: alu_res_d = Source2;
      default: alu_wb_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      acc_q     <= 32'd0;
      mdest_q   <= 4'd0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= 4'd0;
      wb_data_q <= 32'd0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            if (Opcode == OP_MUL) begin
              state_q  <= S_MUL;
              cnt_q    <= 5'd0;
              mcand_q  <= Source1;
              mplier_q <= Source2;
              acc_q    <= 32'd0;
              mdest_q  <= Destination;
            end else if (alu_wb_d) begin
              wb_en_q   <= 1'b1;
              wb_dest_q <= Destination;
              wb_data_q <= alu_res_d;
              zero_q    <= (alu_res_d == 32'd0);
              carry_q   <= alu_carry_d;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          // Final iteration writes the accumulated sum straight to writeback
          if (cnt_q == 5'd31) begin
            state_q   <= S_IDLE;
            wb_en_q   <= 1'b1;
            wb_dest_q <= mdest_q;
            wb_data_q <= acc_d;
            zero_q    <= (acc_d == 32'd0);
            carry_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InReady = (state_q == S_IDLE);
  assign Busy    = (state_q == S_MUL);
  assign WbEn    = wb_en_q;
  assign WbDest  = wb_dest_q;
  assign WbData  = wb_data_q;
  assign Zero    = zero_q;
  assign Carry   = carry_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, iterative MUL timing, back-to-back ops, async reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [3:0]  Opcode = 4'd0;
  logic [3:0]  Destination = 4'd0;
  logic [31:0] Source1 = 32'd0;
  logic [31:0] Source2 = 32'd0;
  logic        WbEn;
  logic [3:0]  WbDest;
  logic [31:0] WbData;
  logic        Zero;
  logic        Carry;
  logic        Busy;

  int n_chk = 0;
  int n_err = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Destination(Destination), .Source1(Source1), .Source2(Source2),
    .WbEn(WbEn), .WbDest(WbDest), .WbData(WbData), .Zero(Zero), .Carry(Carry), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] dst,
                       input logic [31:0] a, input logic [31:0] b);
    InValid     = 1'b1;
    Opcode      = op;
    Destination = dst;
    Source1     = a;
    Source2     = b;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [3:0] dst,
                        input logic [31:0] data, input logic z, input logic c);
    chk({tag, ".en"},   {31'd0, WbEn},  {31'd0, en});
    chk({tag, ".dst"},  {28'd0, WbDest}, {28'd0, dst});
    chk({tag, ".data"}, WbData, data);
    chk({tag, ".zero"}, {31'd0, Zero},  {31'd0, z});
    chk({tag, ".carry"},{31'd0, Carry}, {31'd0, c});
  endtask

  logic [3:0]  b2b_op   [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11, 4'd13};
  logic [31:0] b2b_exp  [8] = '{32'h12345687, 32'h00000008, 32'h1234567F, 32'h12345677,
                                32'h2B3C0000, 32'h00002468, 32'h0000000F, 32'h0000000F};

  initial begin
    int cycles;
    int pulses;

    // Reset state, with a valid ADD presented that must not transfer
    #1 rst = 1'b1;
    drive(4'd0, 4'd1, 32'd1, 32'd1);
    #1;
    chk_wb("rst", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    chk("rst.ready", {31'd0, InReady}, 32'd1);
    chk("rst.busy",  {31'd0, Busy},    32'd0);
    step();
    chk("rst.noxfer", {31'd0, WbEn}, 32'd0);
    #2 rst = 1'b0;
    InValid = 1'b0;
    step();

    // Single-cycle ALU ops
    drive(4'd0, 4'd3, 32'hFFFFFFFF, 32'h00000001);
    step();
    chk_wb("add", 1'b1, 4'd3, 32'h00000000, 1'b1, 1'b1);
    drive(4'd1, 4'd4, 32'd5, 32'd7);
    step();
    chk_wb("sub", 1'b1, 4'd4, 32'hFFFFFFFE, 1'b0, 1'b1);
    drive(4'd7, 4'd5, 32'h80000000, 32'd4);
    step();
    chk_wb("sra", 1'b1, 4'd5, 32'hF8000000, 1'b0, 1'b0);
    drive(4'd8, 4'd0, 32'hFFFFFFFF, 32'd1);
    step();
    chk_wb("slt", 1'b1, 4'd0, 32'd1, 1'b0, 1'b0);
    drive(4'd9, 4'd6, 32'hFFFFFFFF, 32'd1);
    step();
    chk_wb("sltu", 1'b1, 4'd6, 32'd0, 1'b1, 1'b0);
    InValid = 1'b0;
    step();
    chk_wb("idle_hold", 1'b0, 4'd6, 32'd0, 1'b1, 1'b0);

    // Iterative MUL with an ADD held valid behind it
    drive(4'd10, 4'd7, 32'h00010003, 32'h00000005);
    step();
    chk("mul.ready", {31'd0, InReady}, 32'd0);
    chk("mul.busy",  {31'd0, Busy},    32'd1);
    chk("mul.en0",   {31'd0, WbEn},    32'd0);
    drive(4'd0, 4'd1, 32'd2, 32'd3);
    cycles = 0;
    while (cycles < 40) begin
      step();
      cycles++;
      if (WbEn) break;
    end
    chk("mul.latency", cycles, 32);
    chk_wb("mul", 1'b1, 4'd7, 32'h0005000F, 1'b0, 1'b0);
    chk("mul.ready_back", {31'd0, InReady}, 32'd1);
    chk("mul.busy_off",   {31'd0, Busy},    32'd0);
    step();
    chk_wb("add_after_mul", 1'b1, 4'd1, 32'd5, 1'b0, 1'b0);

    // Eight back-to-back ops, last one reserved
    for (int i = 0; i < 8; i++) begin
      drive(b2b_op[i], 4'(i + 1), 32'h12345678, 32'h0000000F);
      step();
      chk($sformatf("b2b%0d.data", i), WbData, b2b_exp[i]);
      chk($sformatf("b2b%0d.en", i), {31'd0, WbEn}, (i < 7) ? 32'd1 : 32'd0);
      chk($sformatf("b2b%0d.dst", i), {28'd0, WbDest}, (i < 7) ? 32'(i + 1) : 32'd7);
    end
    InValid = 1'b0;

    // Reset mid-MUL aborts it
    drive(4'd10, 4'd5, 32'd3, 32'd3);
    step();
    InValid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mulabort.busy_pre", {31'd0, Busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_wb("mulabort.rst", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    chk("mulabort.busy", {31'd0, Busy}, 32'd0);
    chk("mulabort.ready", {31'd0, InReady}, 32'd1);
    step();
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (WbEn) pulses++;
    end
    chk("mulabort.no_wb", pulses, 0);
    drive(4'd0, 4'd2, 32'd2, 32'd2);
    step();
    chk_wb("add_after_rst", 1'b1, 4'd2, 32'd4, 1'b0, 1'b0);
    InValid = 1'b0;
    step();
    chk("add_after_rst.fall", {31'd0, WbEn}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
